mag_req_arbiter: RTL and testbench

Round-robin scheduler sharing one complex-to-magnitude engine (|max|+|min|/4 approximator, one strobe in, result strobe 3 cycles later, at most one operation in flight) between N_REQ requesters in the short-preamble synchronizer, e.g. the autocorrelation and signal-power paths. It accepts one I/Q sample from the granted requester, issues it to the engine, waits for the result and routes it back, tagged with the requester index. Missing or spurious engine results are detected and flagged.

---
 rtl/mag_req_arbiter_pkg.sv | 18 +
 rtl/mag_req_arbiter_rr_grant.sv | 39 +++
 rtl/mag_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_mag_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_req_arbiter_pkg.sv
// Shared types and defaults for the magnitude-engine request arbiter.
package mag_arb_pkg;

  localparam int unsigned DEF_N_REQ   = 2;
  localparam int unsigned DEF_W       = 32;
  localparam int unsigned DEF_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mag_req_arbiter_rr_grant.sv
// Combinational masked-priority round-robin grant: request vector + pointer
// in, one-hot grant and its index out.
module rr_grant
  import mag_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned TW    = tag_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [TW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [TW-1:0]    o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_pick;

  // Requests at or above ptr take precedence; otherwise wrap to the lowest index.
  always_comb begin
    w_hi = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_hi[k] = i_req[k] && (k >= 32'(i_ptr));
    end
    w_pick = (|w_hi) ? w_hi : i_req;
    o_gnt  = '0;
    o_idx  = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (w_pick[k-1]) begin
        o_gnt      = '0;
        o_gnt[k-1] = 1'b1;
        o_idx      = TW'(k-1);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mag_req_arbiter.sv
// Round-robin sharing of one |I/Q| magnitude engine between N_REQ requesters,
// with detection of lost (timeout) and spurious engine results.
module mag_req_arbiter
  import mag_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               CLK,
  input  logic               a_RST_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_i,
  input  logic [N_REQ*W-1:0] req_q,
  output logic [N_REQ-1:0]   req_ready,
  output logic               eng_stb,
  output logic [W-1:0]       eng_i,
  output logic [W-1:0]       eng_q,
  input  logic               eng_mag_stb,
  input  logic [W-1:0]       eng_mag,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_mag,
  output logic               busy,
  input  logic               err_clr,
  output logic               err_timeout,
  output logic               err_unexpected
);

  localparam int unsigned TW = tag_w(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_e       r_state, w_state_nxt;
  logic [TW-1:0]    r_ptr, r_tag, w_gidx, w_ptr_nxt;
  logic [N_REQ-1:0] w_gnt;
  logic             w_any;
  logic [CW-1:0]    r_cnt, w_cnt_inc;
  logic             w_xfer, w_rsp_evt, w_tmo_evt, w_unexp_evt;
  logic [W-1:0]     w_sel_i, w_sel_q;
  logic [W-1:0]     r_eng_i, r_eng_q, r_rsp_mag;
  logic [N_REQ-1:0] r_rsp_valid;
  logic             r_err_timeout, r_err_unexpected;

  rr_grant #(
    .N_REQ (N_REQ),
    .TW    (TW)
  ) u_grant (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_ptr_nxt   = (w_gidx == TW'(N_REQ - 1)) ? '0 : w_gidx + TW'(1);
  assign w_unexp_evt = eng_mag_stb && (r_state != ST_WAIT);

  always_comb begin
    w_sel_i = '0;
    w_sel_q = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_i = req_i[k*W +: W];
        w_sel_q = req_q[k*W +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_rsp_evt   = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_xfer      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A result arriving on the final count still wins over the timeout.
        if (eng_mag_stb) begin
          w_rsp_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_tmo_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      r_state          <= ST_IDLE;
      r_ptr            <= '0;
      r_tag            <= '0;
      r_cnt            <= '0;
      r_eng_i          <= '0;
      r_eng_q          <= '0;
      r_rsp_valid      <= '0;
      r_rsp_mag        <= '0;
      r_err_timeout    <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_eng_i <= w_sel_i;
        r_eng_q <= w_sel_q;
        r_tag   <= w_gidx;
        r_ptr   <= w_ptr_nxt;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
        r_rsp_valid[k] <= w_rsp_evt && (r_tag == TW'(k));
      end
      if (w_rsp_evt) begin
        r_rsp_mag <= eng_mag;
      end
      if (w_tmo_evt) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr) begin
        r_err_timeout <= 1'b0;
      end
      if (w_unexp_evt) begin
        r_err_unexpected <= 1'b1;
      end else if (err_clr) begin
        r_err_unexpected <= 1'b0;
      end
    end
  end

  // Ready is gated by reset so it stays low while the block is held in reset.
  assign req_ready      = (r_state == ST_IDLE && a_RST_n) ? w_gnt : '0;
  assign eng_stb        = (r_state == ST_ISSUE);
  assign busy           = (r_state != ST_IDLE);
  assign eng_i          = r_eng_i;
  assign eng_q          = r_eng_q;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_mag        = r_rsp_mag;
  assign err_timeout    = r_err_timeout;
  assign err_unexpected = r_err_unexpected;

endmodule

// File: tb/tb_mag_req_arbiter.sv
// Directed bench for mag_req_arbiter with hand-computed expected values.
module tb_mag_req_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 8;

  logic               CLK = 1'b0;
  logic               a_RST_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_i, req_q;
  logic [N_REQ-1:0]   req_ready;
  logic               eng_stb;
  logic [W-1:0]       eng_i, eng_q;
  logic               eng_mag_stb;
  logic [W-1:0]       eng_mag;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_mag;
  logic               busy;
  logic               err_clr;
  logic               err_timeout, err_unexpected;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int c_stb [4];
  int c_tmp;

  mag_req_arbiter #(
    .N_REQ   (N_REQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .a_RST_n        (a_RST_n),
    .req_valid      (req_valid),
    .req_i          (req_i),
    .req_q          (req_q),
    .req_ready      (req_ready),
    .eng_stb        (eng_stb),
    .eng_i          (eng_i),
    .eng_q          (eng_q),
    .eng_mag_stb    (eng_mag_stb),
    .eng_mag        (eng_mag),
    .rsp_valid      (rsp_valid),
    .rsp_mag        (rsp_mag),
    .busy           (busy),
    .err_clr        (err_clr),
    .err_timeout    (err_timeout),
    .err_unexpected (err_unexpected)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic set_req(input logic [1:0] v, input logic [31:0] i0, q0, i1, q1);
    req_valid = v;
    req_i     = {i1, i0};
    req_q     = {q1, q0};
  endtask

  // Entered at a sample point in an IDLE cycle with req_valid already driven.
  task automatic do_txn(input int g, input logic [31:0] ei, eq, mag,
                        input int lat, input bit drop, output int stb_cyc);
    logic [1:0] oh;
    oh = 2'b01 << g;
    #1;
    chk("grant", req_ready, oh);
    chk("idle_busy", busy, 0);
    nxt();
    if (drop) req_valid = '0;
    smp();
    chk("eng_stb", eng_stb, 1);
    chk("eng_i", eng_i, ei);
    chk("eng_q", eng_q, eq);
    chk("wait_busy", busy, 1);
    stb_cyc = cyc;
    for (int d = 1; d <= lat; d++) begin
      nxt();
      if (d == lat) begin
        eng_mag_stb = 1'b1;
        eng_mag     = mag;
      end
      smp();
      if (d == 1) chk("stb_once", eng_stb, 0);
      chk("early_rsp", rsp_valid, 0);
    end
    nxt();
    eng_mag_stb = 1'b0;
    smp();
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_mag", rsp_mag, mag);
    chk("rsp_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_RST_n     = 1'b0;
    req_valid   = 2'b01;
    req_i       = '0;
    req_q       = '0;
    eng_mag_stb = 1'b0;
    eng_mag     = '0;
    err_clr     = 1'b0;
    repeat (2) @(posedge CLK);
    smp();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", eng_stb, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_tmo", err_timeout, 0);
    chk("rst_unexp", err_unexpected, 0);

    // Single request, nominal latency
    nxt();
    a_RST_n = 1'b1;
    set_req(2'b01, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd0);
    do_txn(0, 32'hFFFF_FFFD, 32'd4, 32'd5, 3, 1'b1, c_tmp);
    nxt();
    smp();
    chk("rsp_pulse_len", rsp_valid, 0);

    // Both requesters held valid: alternating grants, 5-cycle strobe spacing
    nxt();
    a_RST_n = 1'b0;
    nxt();
    a_RST_n = 1'b1;
    smp();
    set_req(2'b11, 32'd100, 32'd7, 32'hFFFF_FF38, 32'hFFFF_FFF8);
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0)
        do_txn(0, 32'd100, 32'd7, 32'(10 + t), 3, 1'b0, c_stb[t]);
      else
        do_txn(1, 32'hFFFF_FF38, 32'hFFFF_FFF8, 32'(10 + t), 3, 1'b0, c_stb[t]);
      if (t > 0) chk("stb_gap", 64'(c_stb[t] - c_stb[t-1]), 5);
    end
    req_valid = '0;

    // Engine silent: timeout after WAIT count 8
    nxt();
    set_req(2'b01, 32'd11, 32'd22, 32'd0, 32'd0);
    #1;
    chk("tmo_grant", req_ready, 2'b01);
    nxt();
    req_valid = '0;
    smp();
    chk("tmo_stb", eng_stb, 1);
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      nxt();
      smp();
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_wait_flag", err_timeout, 0);
      chk("tmo_wait_rsp", rsp_valid, 0);
    end
    nxt();
    smp();
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_rsp", rsp_valid, 0);
    set_req(2'b10, 32'd0, 32'd0, 32'd33, 32'd44);
    do_txn(1, 32'd33, 32'd44, 32'd55, 3, 1'b1, c_tmp);
    chk("tmo_sticky", err_timeout, 1);
    nxt();
    err_clr = 1'b1;
    smp();
    chk("clr_not_yet", err_timeout, 1);
    nxt();
    err_clr = 1'b0;
    smp();
    chk("tmo_cleared", err_timeout, 0);

    // Spurious engine result while IDLE
    nxt();
    eng_mag_stb = 1'b1;
    eng_mag     = 32'd77;
    smp();
    chk("unexp_delay", err_unexpected, 0);
    nxt();
    eng_mag_stb = 1'b0;
    smp();
    chk("unexp_flag", err_unexpected, 1);
    chk("unexp_rsp", rsp_valid, 0);
    nxt();
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    smp();
    chk("unexp_cleared", err_unexpected, 0);
    nxt();
    eng_mag_stb = 1'b1;
    err_clr     = 1'b1;
    nxt();
    eng_mag_stb = 1'b0;
    err_clr     = 1'b0;
    smp();
    chk("set_wins", err_unexpected, 1);

    // Result on exactly WAIT count 8 beats the timeout
    set_req(2'b01, 32'd5, 32'd6, 32'd0, 32'd0);
    do_txn(0, 32'd5, 32'd6, 32'd99, int'(TIMEOUT), 1'b1, c_tmp);
    chk("edge_no_tmo", err_timeout, 0);
    nxt();
    smp();
    chk("edge_no_tmo_late", err_timeout, 0);

    // Reset during WAIT
    set_req(2'b01, 32'd8, 32'd9, 32'd0, 32'd0);
    #1;
    chk("rw_grant", req_ready, 2'b01);
    nxt();
    req_valid = '0;
    smp();
    chk("rw_stb", eng_stb, 1);
    nxt();
    smp();
    set_req(2'b11, 32'd8, 32'd9, 32'd12, 32'd13);
    #1;
    a_RST_n = 1'b0;
    #1;
    chk("rw_ready", req_ready, 0);
    chk("rw_stb0", eng_stb, 0);
    chk("rw_eng_i", eng_i, 0);
    chk("rw_eng_q", eng_q, 0);
    chk("rw_rsp", rsp_valid, 0);
    chk("rw_mag", rsp_mag, 0);
    chk("rw_busy", busy, 0);
    chk("rw_tmo", err_timeout, 0);
    chk("rw_unexp", err_unexpected, 0);
    nxt();
    a_RST_n = 1'b1;
    #1;
    chk("rw_ptr0", req_ready, 2'b01);
    smp();
    req_valid = '0;
    nxt();
    eng_mag_stb = 1'b1;
    eng_mag     = 32'd5;
    nxt();
    eng_mag_stb = 1'b0;
    smp();
    chk("stale_unexp", err_unexpected, 1);
    chk("stale_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
